// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI-Lite master arbiter.
package axil_arb_pkg;

  localparam int unsigned AXIL_ADDR_W = 32;
  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StResp,
    StErr,
    StDrain
  } path_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnReq0 = 2'd1,
    OwnReq1 = 2'd2
  } owner_e;

  function automatic owner_e owner_enc(input logic busy, input logic sel);
    if (!busy) return OwnNone;
    if (sel) return OwnReq1;
    return OwnReq0;
  endfunction

endpackage

// File: rtl/axil_rw_if.sv
// AXI-Lite read/write bundle; producer is the master side, consumer the slave side.
interface axil_rw_if;
  logic [axil_arb_pkg::AXIL_ADDR_W-1:0] awaddr;
  logic                                 awvalid;
  logic                                 awready;
  logic [axil_arb_pkg::AXIL_DATA_W-1:0] wdata;
  logic [axil_arb_pkg::AXIL_STRB_W-1:0] wstrb;
  logic                                 wvalid;
  logic                                 wready;
  logic [1:0]                           bresp;
  logic                                 bvalid;
  logic                                 bready;
  logic [axil_arb_pkg::AXIL_ADDR_W-1:0] araddr;
  logic                                 arvalid;
  logic                                 arready;
  logic [axil_arb_pkg::AXIL_DATA_W-1:0] rdata;
  logic [1:0]                           rresp;
  logic                                 rvalid;
  logic                                 rready;

  modport producer (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport consumer (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_rr_arb2.sv
// Two-input round-robin picker; last-granted register resets to requester 1.
module axil_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       pick,
  output logic       any
);

  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_idx;
    end
  end

  always_comb begin
    any = |req;
    unique case (req)
      2'b11:   pick = ~last_q;
      2'b10:   pick = 1'b1;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/axil_master_arb.sv
// Arbitrates two AXI-Lite requesters onto one master port, write and read paths independent.
// Define AXIL_ARB_TIMEOUT_EN to build in the downstream response watchdog.
module axil_master_arb
  import axil_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  axil_rw_if.consumer req0_axil_if,
  axil_rw_if.consumer req1_axil_if,
  axil_rw_if.producer mst_axil_if,
  output logic [1:0]  wr_owner,
  output logic [1:0]  rd_owner,
  output logic [7:0]  timeout_cnt
);

  path_state_e wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic aw_hold_q, aw_hold_d, w_hold_q, w_hold_d, ar_hold_q, ar_hold_d;
  logic wr_pick, wr_any, wr_upd, rd_pick, rd_any, rd_upd;
  logic wr_tmo_exp, rd_tmo_exp;

  logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic [1:0] g_bresp, g_rresp;
  logic [AXIL_DATA_W-1:0] g_rdata;
  logic wr_busy, rd_busy, wr_g0, wr_g1, rd_g0, rd_g1;

  axil_rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_axil_if.awvalid, req0_axil_if.awvalid}),
    .upd     (wr_upd),
    .upd_idx (wr_sel_q),
    .pick    (wr_pick),
    .any     (wr_any)
  );

  axil_rr_arb2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_axil_if.arvalid, req0_axil_if.arvalid}),
    .upd     (rd_upd),
    .upd_idx (rd_sel_q),
    .pick    (rd_pick),
    .any     (rd_any)
  );

  assign s_awvalid = wr_sel_q ? req1_axil_if.awvalid : req0_axil_if.awvalid;
  assign s_wvalid  = wr_sel_q ? req1_axil_if.wvalid  : req0_axil_if.wvalid;
  assign s_bready  = wr_sel_q ? req1_axil_if.bready  : req0_axil_if.bready;
  assign s_arvalid = rd_sel_q ? req1_axil_if.arvalid : req0_axil_if.arvalid;
  assign s_rready  = rd_sel_q ? req1_axil_if.rready  : req0_axil_if.rready;

  assign mst_axil_if.awaddr  = wr_sel_q ? req1_axil_if.awaddr : req0_axil_if.awaddr;
  assign mst_axil_if.wdata   = wr_sel_q ? req1_axil_if.wdata  : req0_axil_if.wdata;
  assign mst_axil_if.wstrb   = wr_sel_q ? req1_axil_if.wstrb  : req0_axil_if.wstrb;
  assign mst_axil_if.araddr  = rd_sel_q ? req1_axil_if.araddr : req0_axil_if.araddr;
  assign mst_axil_if.awvalid = m_awvalid;
  assign mst_axil_if.wvalid  = m_wvalid;
  assign mst_axil_if.bready  = m_bready;
  assign mst_axil_if.arvalid = m_arvalid;
  assign mst_axil_if.rready  = m_rready;

  // Write path: AW and W complete independently; each is masked once accepted.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_sel_d   = wr_sel_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_hold_d  = 1'b0;
    w_hold_d   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    g_awready  = 1'b0;
    g_wready   = 1'b0;
    g_bvalid   = 1'b0;
    g_bresp    = RESP_OKAY;
    wr_upd     = 1'b0;
    unique case (wr_state_q)
      StIdle: begin
        if (wr_any) begin
          wr_state_d = StAddr;
          wr_sel_d   = wr_pick;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      StAddr: begin
        // Hold flags keep downstream valid up even if the requester drops it early.
        m_awvalid = !aw_done_q && (s_awvalid || aw_hold_q);
        m_wvalid  = !w_done_q && (s_wvalid || w_hold_q);
        g_awready = !aw_done_q && mst_axil_if.awready;
        g_wready  = !w_done_q && mst_axil_if.wready;
        aw_hold_d = m_awvalid && !mst_axil_if.awready;
        w_hold_d  = m_wvalid && !mst_axil_if.wready;
        if (m_awvalid && mst_axil_if.awready) aw_done_d = 1'b1;
        if (m_wvalid && mst_axil_if.wready) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) wr_state_d = StResp;
      end
      StResp: begin
        m_bready = s_bready;
        g_bvalid = mst_axil_if.bvalid;
        g_bresp  = mst_axil_if.bresp;
        if (mst_axil_if.bvalid && s_bready) begin
          wr_state_d = StIdle;
          wr_upd     = 1'b1;
        end else if (!mst_axil_if.bvalid && wr_tmo_exp) begin
          wr_state_d = StErr;
        end
      end
      StErr: begin
        g_bvalid = 1'b1;
        g_bresp  = RESP_SLVERR;
        if (s_bready) begin
          wr_state_d = StDrain;
          wr_upd     = 1'b1;
        end
      end
      StDrain: begin
        m_bready = 1'b1;
        if (mst_axil_if.bvalid || wr_tmo_exp) wr_state_d = StIdle;
      end
      default: wr_state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_sel_d   = rd_sel_q;
    ar_hold_d  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    g_arready  = 1'b0;
    g_rvalid   = 1'b0;
    g_rresp    = RESP_OKAY;
    g_rdata    = '0;
    rd_upd     = 1'b0;
    unique case (rd_state_q)
      StIdle: begin
        if (rd_any) begin
          rd_state_d = StAddr;
          rd_sel_d   = rd_pick;
        end
      end
      StAddr: begin
        m_arvalid = s_arvalid || ar_hold_q;
        g_arready = mst_axil_if.arready;
        ar_hold_d = m_arvalid && !mst_axil_if.arready;
        if (m_arvalid && mst_axil_if.arready) rd_state_d = StResp;
      end
      StResp: begin
        m_rready = s_rready;
        g_rvalid = mst_axil_if.rvalid;
        g_rresp  = mst_axil_if.rresp;
        g_rdata  = mst_axil_if.rdata;
        if (mst_axil_if.rvalid && s_rready) begin
          rd_state_d = StIdle;
          rd_upd     = 1'b1;
        end else if (!mst_axil_if.rvalid && rd_tmo_exp) begin
          rd_state_d = StErr;
        end
      end
      StErr: begin
        g_rvalid = 1'b1;
        g_rresp  = RESP_SLVERR;
        if (s_rready) begin
          rd_state_d = StDrain;
          rd_upd     = 1'b1;
        end
      end
      StDrain: begin
        m_rready = 1'b1;
        if (mst_axil_if.rvalid || rd_tmo_exp) rd_state_d = StIdle;
      end
      default: rd_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= StIdle;
      rd_state_q <= StIdle;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      aw_hold_q  <= 1'b0;
      w_hold_q   <= 1'b0;
      ar_hold_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      aw_hold_q  <= aw_hold_d;
      w_hold_q   <= w_hold_d;
      ar_hold_q  <= ar_hold_d;
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wr_tmo_q, rd_tmo_q;
  logic [7:0]  tmo_cnt_q;
  logic [8:0]  tmo_sum;
  logic        wr_to_err, rd_to_err;

  assign wr_to_err  = (wr_state_q == StResp) && (wr_state_d == StErr);
  assign rd_to_err  = (rd_state_q == StResp) && (rd_state_d == StErr);
  assign wr_tmo_exp = (wr_tmo_q == TmoLast);
  assign rd_tmo_exp = (rd_tmo_q == TmoLast);
  assign tmo_sum    = {1'b0, tmo_cnt_q} + 9'(wr_to_err) + 9'(rd_to_err);
  assign timeout_cnt = tmo_cnt_q;

  // Counters restart on every state change, so they measure time spent in RESP or DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_tmo_q  <= '0;
      rd_tmo_q  <= '0;
      tmo_cnt_q <= '0;
    end else begin
      wr_tmo_q  <= (wr_state_d != wr_state_q) ? 16'd0 : wr_tmo_q + 16'd1;
      rd_tmo_q  <= (rd_state_d != rd_state_q) ? 16'd0 : rd_tmo_q + 16'd1;
      tmo_cnt_q <= tmo_sum[8] ? 8'hff : tmo_sum[7:0];
    end
  end
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = ^32'(TIMEOUT_CYCLES);
  assign wr_tmo_exp     = 1'b0;
  assign rd_tmo_exp     = 1'b0;
  assign timeout_cnt    = '0;
`endif

  assign wr_busy = (wr_state_q != StIdle);
  assign rd_busy = (rd_state_q != StIdle);
  assign wr_g0   = wr_busy && !wr_sel_q;
  assign wr_g1   = wr_busy && wr_sel_q;
  assign rd_g0   = rd_busy && !rd_sel_q;
  assign rd_g1   = rd_busy && rd_sel_q;
  assign wr_owner = owner_enc(wr_busy, wr_sel_q);
  assign rd_owner = owner_enc(rd_busy, rd_sel_q);

  assign req0_axil_if.awready = wr_g0 && g_awready;
  assign req0_axil_if.wready  = wr_g0 && g_wready;
  assign req0_axil_if.bvalid  = wr_g0 && g_bvalid;
  assign req0_axil_if.bresp   = g_bresp;
  assign req0_axil_if.arready = rd_g0 && g_arready;
  assign req0_axil_if.rvalid  = rd_g0 && g_rvalid;
  assign req0_axil_if.rresp   = g_rresp;
  assign req0_axil_if.rdata   = g_rdata;

  assign req1_axil_if.awready = wr_g1 && g_awready;
  assign req1_axil_if.wready  = wr_g1 && g_wready;
  assign req1_axil_if.bvalid  = wr_g1 && g_bvalid;
  assign req1_axil_if.bresp   = g_bresp;
  assign req1_axil_if.arready = rd_g1 && g_arready;
  assign req1_axil_if.rvalid  = rd_g1 && g_rvalid;
  assign req1_axil_if.rresp   = g_rresp;
  assign req1_axil_if.rdata   = g_rdata;

endmodule

// File: tb/tb_axil_master_arb.sv
// Directed bench for axil_master_arb; the watchdog scenario runs when AXIL_ARB_TIMEOUT_EN is set.
module tb_axil_master_arb;

  logic       clk;
  logic       rst;
  logic [1:0] wr_owner;
  logic [1:0] rd_owner;
  logic [7:0] timeout_cnt;
  int         n_checks;
  int         n_pass;

  axil_rw_if r0 ();
  axil_rw_if r1 ();
  axil_rw_if m ();

  axil_master_arb #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_axil_if (r0),
    .req1_axil_if (r1),
    .mst_axil_if  (m),
    .wr_owner     (wr_owner),
    .rd_owner     (rd_owner),
    .timeout_cnt  (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_set(input int idx, input logic v, input logic [31:0] a, input logic [31:0] d);
    if (idx == 0) begin
      r0.awvalid = v; r0.wvalid = v; r0.awaddr = a; r0.wdata = d; r0.wstrb = 4'hf;
    end else begin
      r1.awvalid = v; r1.wvalid = v; r1.awaddr = a; r1.wdata = d; r1.wstrb = 4'hf;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    wr_set(0, 1'b0, '0, '0);
    wr_set(1, 1'b0, '0, '0);
    r0.bready = 1'b0; r0.arvalid = 1'b0; r0.araddr = '0; r0.rready = 1'b0;
    r1.bready = 1'b0; r1.arvalid = 1'b0; r1.araddr = '0; r1.rready = 1'b0;
    m.awready = 1'b0; m.wready = 1'b0; m.bvalid = 1'b0; m.bresp = 2'b00;
    m.arready = 1'b0; m.rvalid = 1'b0; m.rresp = 2'b00; m.rdata = '0;

    // Reset state
    step(); step();
    check("rst_wr_owner", wr_owner, 2'd0);
    check("rst_rd_owner", rd_owner, 2'd0);
    check("rst_m_awvalid", m.awvalid, 1'b0);
    check("rst_m_arvalid", m.arvalid, 1'b0);
    check("rst_tmo_cnt", timeout_cnt, 8'd0);
    rst = 1'b0;
    step();

    // Lone req0 write
    wr_set(0, 1'b1, 32'h10, 32'ha5);
    r0.bready = 1'b1; r1.bready = 1'b1;
    m.awready = 1'b1; m.wready = 1'b1;
    #1;
    check("w1_idle_awvalid", m.awvalid, 1'b0);
    check("w1_idle_owner", wr_owner, 2'd0);
    step();
    check("w1_m_awvalid", m.awvalid, 1'b1);
    check("w1_m_awaddr", m.awaddr, 32'h10);
    check("w1_m_wvalid", m.wvalid, 1'b1);
    check("w1_m_wdata", m.wdata, 32'ha5);
    check("w1_owner", wr_owner, 2'd1);
    check("w1_r0_awready", r0.awready, 1'b1);
    check("w1_r1_awready", r1.awready, 1'b0);
    step();
    wr_set(0, 1'b0, '0, '0);
    m.bvalid = 1'b1; m.bresp = 2'b00;
    #1;
    check("w1_resp_awvalid", m.awvalid, 1'b0);
    check("w1_r0_bvalid", r0.bvalid, 1'b1);
    check("w1_r0_bresp", r0.bresp, 2'b00);
    check("w1_r1_bvalid", r1.bvalid, 1'b0);
    step();
    m.bvalid = 1'b0;
    check("w1_done_owner", wr_owner, 2'd0);

    // Simultaneous reads: req0 first, one idle cycle, then req1
    r0.arvalid = 1'b1; r0.araddr = 32'h100; r0.rready = 1'b1;
    r1.arvalid = 1'b1; r1.araddr = 32'h200; r1.rready = 1'b1;
    m.arready = 1'b1;
    step();
    check("r2_owner0", rd_owner, 2'd1);
    check("r2_araddr0", m.araddr, 32'h100);
    check("r2_r1_arready", r1.arready, 1'b0);
    step();
    r0.arvalid = 1'b0;
    m.rvalid = 1'b1; m.rdata = 32'h1111; m.rresp = 2'b00;
    #1;
    check("r2_r0_rvalid", r0.rvalid, 1'b1);
    check("r2_r0_rdata", r0.rdata, 32'h1111);
    check("r2_r1_rvalid", r1.rvalid, 1'b0);
    step();
    m.rvalid = 1'b0;
    check("r2_gap_owner", rd_owner, 2'd0);
    step();
    check("r2_owner1", rd_owner, 2'd2);
    check("r2_araddr1", m.araddr, 32'h200);
    step();
    r1.arvalid = 1'b0;
    m.rvalid = 1'b1; m.rdata = 32'h2222;
    #1;
    check("r2_r1_rdata", r1.rdata, 32'h2222);
    check("r2_r0_rvalid_b", r0.rvalid, 1'b0);
    step();
    m.rvalid = 1'b0;
    r0.rready = 1'b0; r1.rready = 1'b0;

    // W accepted three cycles before AW
    wr_set(1, 1'b1, 32'h20, 32'h5a);
    m.awready = 1'b0; m.wready = 1'b1;
    step();
    check("w3_owner", wr_owner, 2'd2);
    check("w3_r1_wready", r1.wready, 1'b1);
    check("w3_r1_awready", r1.awready, 1'b0);
    step();
    r1.wvalid = 1'b0;
    #1;
    check("w3_wvalid_masked", m.wvalid, 1'b0);
    check("w3_awvalid_held", m.awvalid, 1'b1);
    step();
    step();
    m.awready = 1'b1;
    #1;
    check("w3_r1_awready_late", r1.awready, 1'b1);
    step();
    r1.awvalid = 1'b0;
    m.bvalid = 1'b1;
    #1;
    check("w3_r1_bvalid", r1.bvalid, 1'b1);
    check("w3_r0_bvalid", r0.bvalid, 1'b0);
    step();
    m.bvalid = 1'b0;
    check("w3_done_owner", wr_owner, 2'd0);

    // Concurrent req0 write and req1 read
    wr_set(0, 1'b1, 32'h40, 32'h33);
    r1.arvalid = 1'b1; r1.araddr = 32'h50; r1.rready = 1'b1;
    m.awready = 1'b1; m.wready = 1'b1; m.arready = 1'b1;
    step();
    check("c6_wr_owner", wr_owner, 2'd1);
    check("c6_rd_owner", rd_owner, 2'd2);
    step();
    wr_set(0, 1'b0, '0, '0);
    r1.arvalid = 1'b0;
    m.bvalid = 1'b1; m.rvalid = 1'b1; m.rdata = 32'h99;
    #1;
    check("c6_r0_bvalid", r0.bvalid, 1'b1);
    check("c6_r1_rdata", r1.rdata, 32'h99);
    check("c6_r1_bvalid", r1.bvalid, 1'b0);
    check("c6_r0_rvalid", r0.rvalid, 1'b0);
    step();
    m.bvalid = 1'b0; m.rvalid = 1'b0; r1.rready = 1'b0;

    // Reset pulse while req1 write sits in RESP
    wr_set(1, 1'b1, 32'h60, 32'h77);
    step();
    step();
    wr_set(1, 1'b0, '0, '0);
    step();
    check("r5_pre_owner", wr_owner, 2'd2);
    rst = 1'b1;
    step();
    check("r5_rst_owner", wr_owner, 2'd0);
    check("r5_rst_bready", m.bready, 1'b0);
    check("r5_rst_r1_bvalid", r1.bvalid, 1'b0);
    rst = 1'b0;
    wr_set(0, 1'b1, 32'h70, 32'h1);
    wr_set(1, 1'b1, 32'h80, 32'h2);
    step();
    check("r5_grant_req0", wr_owner, 2'd1);
    check("r5_r1_awready", r1.awready, 1'b0);
    step();
    wr_set(0, 1'b0, '0, '0);
    m.bvalid = 1'b1;
    step();
    m.bvalid = 1'b0;
    step();
    check("r5_grant_req1", wr_owner, 2'd2);
    step();
    wr_set(1, 1'b0, '0, '0);
    m.bvalid = 1'b1;
    step();
    m.bvalid = 1'b0;

    // Read left unanswered by the downstream slave
    r1.arvalid = 1'b1; r1.araddr = 32'h300; r1.rready = 1'b0;
    m.rdata = 32'hdead_beef; m.rresp = 2'b00;
    step();
    step();
    r1.arvalid = 1'b0;
    repeat (15) step();
    check("t4_no_early_rvalid", r1.rvalid, 1'b0);
`ifdef AXIL_ARB_TIMEOUT_EN
    step();
    check("t4_err_rvalid", r1.rvalid, 1'b1);
    check("t4_err_rresp", r1.rresp, 2'b10);
    check("t4_err_rdata", r1.rdata, 32'h0);
    check("t4_tmo_cnt", timeout_cnt, 8'd1);
    check("t4_err_m_rready", m.rready, 1'b0);
    r1.rready = 1'b1;
    step();
    r1.rready = 1'b0;
    check("t4_drain_m_rready", m.rready, 1'b1);
    check("t4_drain_owner", rd_owner, 2'd2);
    m.rvalid = 1'b1;
    #1;
    check("t4_drain_r1_rvalid", r1.rvalid, 1'b0);
    step();
    m.rvalid = 1'b0;
    check("t4_drain_done_owner", rd_owner, 2'd0);
    r1.arvalid = 1'b1; r1.araddr = 32'h304;
    step();
    step();
    r1.arvalid = 1'b0;
`else
    repeat (5) step();
    check("t4_owner_held", rd_owner, 2'd2);
    check("t4_tmo_cnt_zero", timeout_cnt, 8'd0);
`endif
    m.rvalid = 1'b1; m.rdata = 32'h1234; m.rresp = 2'b00;
    r1.rready = 1'b1;
    #1;
    check("t4_ok_rvalid", r1.rvalid, 1'b1);
    check("t4_ok_rresp", r1.rresp, 2'b00);
    check("t4_ok_rdata", r1.rdata, 32'h1234);
    step();
    m.rvalid = 1'b0;
    check("t4_final_owner", rd_owner, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_master_arb.md
AXIL_MASTER_ARB -- requirements
Module: axil_master_arb

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1024, downstream response timeout in clk cycles (range 2..65535).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req0_axil_if  axil_rw_if.consumer  -  requester 0 (CPU) AXI-Lite slave side.
REQ-005 SHALL have port: req1_axil_if  axil_rw_if.consumer  -  requester 1 (test host) AXI-Lite slave side.
REQ-006 SHALL have port: mst_axil_if  axil_rw_if.producer  -  shared AXI-Lite master port toward the interconnect.
REQ-007 SHALL have port: wr_owner  output  2  write-path owner: 0 none, 1 req0, 2 req1.
REQ-008 SHALL have port: rd_owner  output  2  read-path owner, same encoding.
REQ-009 SHALL have port: timeout_cnt  output  8  saturating count of timed-out transactions (0 without timeout feature).

Function
REQ-010 SHALL arbitrate the write path (AW/W/B) and the read path (AR/R) independently; each path holds at most one outstanding transaction.
REQ-011 SHALL use per-path states IDLE, ADDR, RESP, ERR, DRAIN.
REQ-012 IDLE: requester counts as requesting when awvalid (write) or arvalid (read) is high; grant is registered, so ADDR is entered one cycle after the request is seen.
REQ-013 Round-robin: on a simultaneous request, the requester not granted last on that path wins; a lone requester always wins; after reset, last-granted is req1, so req0 wins first.
REQ-014 ADDR/RESP: granted requester's channels are connected combinationally to mst_axil_if; non-granted requester sees all ready and valid signals low.
REQ-015 Write ADDR: AW and W may complete downstream in either order or in the same cycle; the state moves to RESP once both handshakes have completed.
REQ-016 Read ADDR: moves to RESP on the AR handshake.
REQ-017 RESP: passes B (or R) through; returns to IDLE on the requester-side bvalid&bready (rvalid&rready) handshake, and updates last-granted in the same cycle.
REQ-018 Minimum back-to-back spacing on one path: one IDLE cycle between transactions.
REQ-019 Downstream valid SHALL NOT drop once asserted until its handshake completes, regardless of requester behaviour.
REQ-020 wr_owner and rd_owner SHALL reflect the granted requester in ADDR, RESP, ERR and DRAIN, and be 0 in IDLE.

Reset
REQ-021 While rst is high: both paths go to IDLE, all valid/ready outputs are 0, owners are 0, last-granted is req1, and the timeout counters and timeout_cnt are 0.
REQ-022 Assertion of rst mid-transaction SHALL abandon the transaction with no response to the requester; it takes effect on the next clk edge.

Configuration
REQ-023 Macro AXIL_ARB_TIMEOUT_EN SHALL compile in the response watchdog.
REQ-024 Defined: a per-path counter starts on entering RESP; on reaching TIMEOUT_CYCLES with no downstream response, the path goes to ERR.
REQ-025 ERR: drives bresp/rresp = 2'b10 (SLVERR) and rdata = 0 to the owner, and increments timeout_cnt (saturating at 255).
REQ-026 After the requester handshake in ERR, the path goes to DRAIN; DRAIN holds bready/rready = 1 downstream, discards the late response, then returns to IDLE.
REQ-027 A downstream response arriving in the same cycle the counter expires SHALL win; no timeout is taken.
REQ-028 Undefined: there are no counters, ERR and DRAIN are unreachable, and timeout_cnt is tied to 0.

Structure
REQ-029 Package axil_arb_pkg SHALL hold the path-state enum, the owner encoding, and the constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
REQ-030 Sub-module axil_rr_arb2 SHALL implement the two-input round-robin pick with last-granted register; it is instantiated once per path.

Verification
REQ-031 req0 write addr 0x10 data 0xA5 alone -> downstream AW/W one cycle later, B OKAY to req0, wr_owner 1 then 0.
REQ-032 req0 and req1 arvalid in the same cycle after reset -> req0 served first, req1 next, with exactly one IDLE cycle between.
REQ-033 Downstream W accepted 3 cycles before AW -> single B delivered to the granted requester only; other requester bvalid stays 0.
REQ-034 With AXIL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, downstream never answers a read -> req1 gets rresp 2'b10 and rdata 0 at cycle 16; timeout_cnt = 1; late R drained; next read OKAY.
REQ-035 rst pulsed for 1 cycle during write RESP -> all outputs 0, owners 0; next simultaneous request is granted to req0.
REQ-036 Concurrent req0 write and req1 read -> both paths active at once; wr_owner = 1 and rd_owner = 2 in the same cycle.
